// File: rtl/xcorr_peak_pkg.sv
// rtl/xcorr_peak_pkg.sv - shared types and sizing for the peak detector; XCORR_PEAK_SQ_MAG_EN selects squared magnitude
package xcorr_peak_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DRAIN,
        REPORT
    } state_e;

`ifdef XCORR_PEAK_SQ_MAG_EN
    localparam int MAG_W   = 65;
    localparam int MAG_LAT = 3;
`else
    localparam int MAG_W   = 33;
    localparam int MAG_LAT = 2;
`endif

    typedef struct packed {
        logic signed [31:0] i;
        logic signed [31:0] q;
    } iq_t;

    // Correlation sums carry I in the upper word and Q in the lower word
    function automatic iq_t split_iq(input logic [63:0] s);
        iq_t r;
        r.i = s[63:32];
        r.q = s[31:0];
        return r;
    endfunction

endpackage

// File: rtl/xcorr_mag.sv
// rtl/xcorr_mag.sv - magnitude pipeline with matching tag chain; XCORR_PEAK_SQ_MAG_EN selects I*I+Q*Q
module xcorr_mag
    import xcorr_peak_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush_i,
    input  logic [63:0]      sum_i,
    input  logic             in_valid_i,
    input  logic [IDX_W-1:0] in_idx_i,
    input  logic             in_last_i,
    output logic [MAG_W-1:0] mag_o,
    output logic             mag_valid_o,
    output logic [IDX_W-1:0] mag_idx_o,
    output logic             mag_last_o
);
    iq_t iq;
    assign iq = split_iq(sum_i);

    logic [MAG_W-1:0] mag_q;

`ifdef XCORR_PEAK_SQ_MAG_EN
    logic signed [63:0] ii_ext, qq_ext;
    logic [63:0] sq_i_q, sq_q_q, sq_i2_q, sq_q2_q;
    assign ii_ext = iq.i;
    assign qq_ext = iq.q;

    // Squares, a retiming stage, then the exact 65-bit sum
    always_ff @(posedge clock) begin
        if (reset) begin
            sq_i_q  <= '0;
            sq_q_q  <= '0;
            sq_i2_q <= '0;
            sq_q2_q <= '0;
            mag_q   <= '0;
        end else if (enable) begin
            sq_i_q  <= ii_ext * ii_ext;
            sq_q_q  <= qq_ext * qq_ext;
            sq_i2_q <= sq_i_q;
            sq_q2_q <= sq_q_q;
            mag_q   <= {1'b0, sq_i2_q} + {1'b0, sq_q2_q};
        end
    end
`else
    logic [31:0] abs_i_q, abs_q_q;

    // Two's-complement negate of -2^31 yields 2^31 as unsigned, so no saturation
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    // Absolute values, then the 33-bit sum
    always_ff @(posedge clock) begin
        if (reset) begin
            abs_i_q <= '0;
            abs_q_q <= '0;
            mag_q   <= '0;
        end else if (enable) begin
            abs_i_q <= abs32(iq.i);
            abs_q_q <= abs32(iq.q);
            mag_q   <= {1'b0, abs_i_q} + {1'b0, abs_q_q};
        end
    end
`endif

    logic [MAG_LAT-1:0] vld_q, last_q;
    logic [IDX_W-1:0]   idx_q [MAG_LAT];

    // Tags travel alongside the datapath; a flush kills tags of the abandoned window
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int k = 0; k < MAG_LAT; k++) idx_q[k] <= '0;
        end else if (enable) begin
            vld_q[0]  <= in_valid_i;
            last_q[0] <= in_last_i;
            idx_q[0]  <= in_idx_i;
            for (int k = 1; k < MAG_LAT; k++) begin
                vld_q[k]  <= vld_q[k-1] & ~flush_i;
                last_q[k] <= last_q[k-1];
                idx_q[k]  <= idx_q[k-1];
            end
        end
    end

    assign mag_o       = mag_q;
    assign mag_valid_o = vld_q[MAG_LAT-1];
    assign mag_idx_o   = idx_q[MAG_LAT-1];
    assign mag_last_o  = vld_q[MAG_LAT-1] & last_q[MAG_LAT-1];

endmodule

// File: rtl/xcorr_peak_detect.sv
// rtl/xcorr_peak_detect.sv - windowed correlation peak search; magnitude form set by XCORR_PEAK_SQ_MAG_EN
module xcorr_peak_detect
    import xcorr_peak_pkg::*;
#(
    parameter int WINDOW = 128,
    parameter int IDX_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [63:0]      sum,
    input  logic             input_strobe,
    input  logic [MAG_W-1:0] threshold,
    output logic             busy,
    output logic             peak_valid,
    output logic             peak_found,
    output logic [IDX_W-1:0] peak_index,
    output logic [MAG_W-1:0] peak_mag
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
    logic [MAG_W-1:0] max_q, max_d;
    logic [IDX_W-1:0] peak_index_q, peak_index_d;
    logic [MAG_W-1:0] peak_mag_q, peak_mag_d;
    logic             peak_found_q, peak_found_d;

    logic             accept, tag_last;
    logic [IDX_W-1:0] tag_idx;
    logic [MAG_W-1:0] mag, cand_max;
    logic [IDX_W-1:0] mag_idx, cand_idx;
    logic             mag_valid, mag_last;

    // A strobe joins the window while searching, or in the very cycle that arms it
    assign accept   = enable & input_strobe & (start | (state_q == SEARCH));
    assign tag_idx  = start ? '0 : count_q;
    assign tag_last = (tag_idx == LAST_IDX);

    xcorr_mag #(.IDX_W(IDX_W)) u_mag (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .flush_i     (start),
        .sum_i       (sum),
        .in_valid_i  (accept),
        .in_idx_i    (tag_idx),
        .in_last_i   (tag_last),
        .mag_o       (mag),
        .mag_valid_o (mag_valid),
        .mag_idx_o   (mag_idx),
        .mag_last_o  (mag_last)
    );

    // Strictly-greater update so ties keep the earliest index
    assign cand_max = (mag > max_q) ? mag     : max_q;
    assign cand_idx = (mag > max_q) ? mag_idx : max_idx_q;

    // Next-state, counter and tracking logic; start overrides everything
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        max_d        = max_q;
        max_idx_d    = max_idx_q;
        peak_index_d = peak_index_q;
        peak_mag_d   = peak_mag_q;
        peak_found_d = peak_found_q;
        if (enable) begin
            if (start) begin
                state_d   = (accept && tag_last) ? DRAIN : SEARCH;
                count_d   = accept ? IDX_W'(1) : '0;
                max_d     = '0;
                max_idx_d = '0;
            end else begin
                if (accept) count_d = count_q + 1'b1;
                if (mag_valid) begin
                    max_d     = cand_max;
                    max_idx_d = cand_idx;
                end
                case (state_q)
                    SEARCH: if (accept && tag_last) state_d = DRAIN;
                    DRAIN: begin
                        if (mag_last) begin
                            state_d      = REPORT;
                            peak_index_d = cand_idx;
                            peak_mag_d   = cand_max;
                            peak_found_d = (cand_max >= threshold);
                        end
                    end
                    REPORT:  state_d = IDLE;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // State and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            max_q        <= '0;
            max_idx_q    <= '0;
            peak_index_q <= '0;
            peak_mag_q   <= '0;
            peak_found_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            max_q        <= max_d;
            max_idx_q    <= max_idx_d;
            peak_index_q <= peak_index_d;
            peak_mag_q   <= peak_mag_d;
            peak_found_q <= peak_found_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign peak_valid = (state_q == REPORT);
    assign peak_found = peak_found_q;
    assign peak_index = peak_index_q;
    assign peak_mag   = peak_mag_q;

endmodule

// File: tb/tb_xcorr_peak_detect.sv
// tb/tb_xcorr_peak_detect.sv - scoreboard bench for xcorr_peak_detect
module tb_xcorr_peak_detect;
    import xcorr_peak_pkg::*;

    localparam int WIN = 128;
    localparam int IW  = 8;

    typedef struct {
        logic [IW-1:0]    idx;
        logic [MAG_W-1:0] mag;
        logic             found;
        int               cyc;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset, enable, start, input_strobe;
    logic [63:0]      sum;
    logic [MAG_W-1:0] threshold;
    logic             busy, peak_valid, peak_found;
    logic [IW-1:0]    peak_index;
    logic [MAG_W-1:0] peak_mag;

    xcorr_peak_detect #(.WINDOW(WIN), .IDX_W(IW)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .start        (start),
        .sum          (sum),
        .input_strobe (input_strobe),
        .threshold    (threshold),
        .busy         (busy),
        .peak_valid   (peak_valid),
        .peak_found   (peak_found),
        .peak_index   (peak_index),
        .peak_mag     (peak_mag)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb[$];
    logic [63:0] win [WIN];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [MAG_W-1:0] mag_of(input logic [63:0] s);
        longint i, q;
        i = longint'($signed(s[63:32]));
        q = longint'($signed(s[31:0]));
`ifdef XCORR_PEAK_SQ_MAG_EN
        return MAG_W'(i * i) + MAG_W'(q * q);
`else
        if (i < 0) i = -i;
        if (q < 0) q = -q;
        return MAG_W'(i + q);
`endif
    endfunction

    function automatic exp_t model(input logic [MAG_W-1:0] thr);
        exp_t r;
        r.idx = '0;
        r.mag = '0;
        r.cyc = 0;
        for (int k = 0; k < WIN; k++) begin
            if (mag_of(win[k]) > r.mag) begin
                r.mag = mag_of(win[k]);
                r.idx = IW'(k);
            end
        end
        r.found = (r.mag >= thr);
        return r;
    endfunction

    task automatic set_iq(input int k, input int i, input int q);
        win[k] = {i[31:0], q[31:0]};
    endtask

    task automatic fill(input int span);
        for (int k = 0; k < WIN; k++) begin
            if (span == 0) win[k] = '0;
            else set_iq(k, int'($urandom_range(0, 2 * span)) - span,
                           int'($urandom_range(0, 2 * span)) - span);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 400) begin
            @(posedge clock); #1;
            n++;
        end
        chk("done_in_time", n < 400, 1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    // Arm with index 0 in the start cycle, then stream the rest of the window
    task automatic drive_window(input logic [MAG_W-1:0] thr, input int gap,
                                input int off_at, input int off_len, input int drain_off);
        exp_t e;
        int t_last;
        threshold = thr;
        e = model(thr);
        start = 1'b1; input_strobe = 1'b1; sum = win[0]; t_last = cyc;
        @(posedge clock); #1;
        start = 1'b0; input_strobe = 1'b0;
        chk("busy_rise", busy, 1);
        for (int k = 1; k < WIN; k++) begin
            repeat (gap) begin @(posedge clock); #1; end
            if (k == off_at) begin
                enable = 1'b0; input_strobe = 1'b1; sum = {32'h8000_0000, 32'h8000_0000};
                repeat (off_len) begin @(posedge clock); #1; end
                enable = 1'b1; input_strobe = 1'b0;
            end
            input_strobe = 1'b1; sum = win[k]; t_last = cyc;
            @(posedge clock); #1;
            input_strobe = 1'b0;
        end
        e.cyc = t_last + MAG_LAT + 1 + drain_off;
        sb.push_back(e);
        if (drain_off > 0) begin
            enable = 1'b0;
            repeat (drain_off) begin @(posedge clock); #1; end
            enable = 1'b1;
        end
        wait_done();
    endtask

    // Window of large values that is never allowed to complete
    task automatic drive_partial(input int n);
        start = 1'b1; input_strobe = 1'b1; sum = {32'd30000, 32'd0};
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 1; k < n; k++) begin
            sum = {32'd30000 + 32'(k), 32'd17};
            @(posedge clock); #1;
        end
        input_strobe = 1'b0;
    endtask

    logic prev_valid = 1'b0;
    exp_t got_e;
    always @(negedge clock) begin
        if (prev_valid) chk("busy_fall", busy, 0);
        prev_valid <= peak_valid & ~reset;
        if (!reset && peak_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_peak_valid", 1, 0);
            end else begin
                got_e = sb.pop_front();
                chk("peak_index", peak_index, got_e.idx);
                chk("peak_mag", peak_mag, got_e.mag);
                chk("peak_found", peak_found, got_e.found);
                chk("valid_cycle", cyc, got_e.cyc);
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b1; start = 1'b0; input_strobe = 1'b0;
        sum = '0; threshold = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_peak_found", peak_found, 0);
        chk("rst_peak_index", peak_index, 0);
        chk("rst_peak_mag", peak_mag, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        fill(0); set_iq(37, 1000, -500);
        drive_window(1000, 0, 0, 0, 0);

        fill(0); set_iq(10, 200, 0); set_iq(90, 0, -200);
        drive_window(500, 0, 0, 0, 0);

        fill(999); set_iq(5, 32'h8000_0000, 32'h8000_0000);
        drive_window(0, 0, 0, 0, 0);

        fill(32767);
        drive_window(40000, 2, 40, 4, 2);
        drive_window(40000, 0, 0, 0, 0);

        drive_partial(60);
        fill(500);
        drive_window(100, 0, 0, 0, 0);

        drive_partial(50);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_peak_index", peak_index, 0);
        chk("midrst_peak_mag", peak_mag, 0);
        chk("midrst_peak_found", peak_found, 0);
        repeat (10) @(posedge clock);
        #1;

        fill(0); set_iq(0, 4, 4); set_iq(127, -7, 3);
        drive_window(10, 0, 0, 0, 0);

        fill(0);
        drive_window(1, 0, 0, 0, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xcorr_peak_detect.md
# xcorr_peak_detect

Correlation peak detector that consumes the complex correlation sums and strobe produced by the 8-tap complex multiply-accumulate stage. It forms a magnitude for every strobed sum and tracks the maximum over an armed window of `WINDOW` samples. At the end of the window it reports the peak index, the peak magnitude and a threshold decision. Long-preamble timing sync uses these results to place the symbol boundary.

## Interface
Parameters:
- `WINDOW`, default 128: number of strobed samples searched per arm; must satisfy 1 ≤ WINDOW ≤ 2^IDX_W.
- `IDX_W`, default 8: width of the sample counter and of `peak_index`.

Ports (one clock; reset is synchronous and active-high):
- `clock`, input, 1: sole clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `enable`, input, 1: when low, all state, pipeline stages and outputs hold, and strobes are ignored.
- `start`, input, 1: one-cycle arm pulse; re-arms if already searching.
- `sum`, input, 64: correlation sum; [63:32] is signed I, [31:0] is signed Q.
- `input_strobe`, input, 1: `sum` is valid this cycle.
- `threshold`, input, MAG_W: minimum magnitude to declare a peak.
- `busy`, output, 1: window armed or still draining.
- `peak_valid`, output, 1: one-cycle result pulse.
- `peak_found`, output, 1: peak_mag ≥ threshold; valid with `peak_valid`, held afterwards.
- `peak_index`, output, IDX_W: window index of the maximum.
- `peak_mag`, output, MAG_W: magnitude of the maximum.

## Operation
- Magnitude, default: |I| + |Q| as unsigned. |−2^31| = 2^31 fits in 32-bit unsigned, so no saturation is needed. MAG_W = 33.
- Input tagging: while armed, each strobe with `enable` high receives index = count of accepted strobes since arm, starting at 0. A strobe in the same cycle as `start` is index 0. The strobe with index WINDOW−1 is tagged last. Strobes when not armed enter no window.
- FSM `IDLE`, `SEARCH`, `DRAIN`, `REPORT`:
  - `IDLE` → `SEARCH` on `start`. Clears count, max = 0, idx = 0.
  - `SEARCH` → `DRAIN` after the last-tagged strobe is accepted.
  - `DRAIN` compares in-flight tagged samples and moves to `REPORT` when the last-tagged magnitude has been compared.
  - `REPORT` pulses `peak_valid`, registers `peak_found`, then returns to `IDLE`.
- Compare rule: update max/idx only when mag > max, strictly greater. Ties keep the earliest index. An all-zero window reports idx 0, mag 0.
- `start` in `SEARCH`/`DRAIN`/`REPORT`: the current window is abandoned with no `peak_valid`. Tags on in-flight samples are invalidated and a fresh window begins as if from `IDLE`.
- `reset` mid-operation: FSM → `IDLE`, in-flight tags cleared, and no result is produced.
- Reset values: `busy`=0, `peak_valid`=0, `peak_found`=0, `peak_index`=0, `peak_mag`=0.

## Timing
- Magnitude pipeline latency L from strobe to magnitude:
  - Default L = 2: abs registered, then sum registered.
  - With the macro, L = 3.
- Last windowed strobe accepted in cycle T → `peak_valid` high in cycle T+L+1. `peak_index`/`peak_mag`/`peak_found` are stable from that cycle until the next arm.
- `busy` rises the cycle after `start` and falls the cycle after `peak_valid`.
- `enable` low cycles stretch all latencies one-for-one.

## Configuration
- `XCORR_PEAK_SQ_MAG_EN` defined: magnitude = I·I + Q·Q, exact with no truncation.
  - MAG_W = 65.
  - L = 3: squares registered, then the pipeline stage, then the sum registered.
  - `threshold` widens to 65 bits.
- Not defined: the |I| + |Q| approximation, MAG_W = 33, L = 2.

## Structure
- Package `xcorr_peak_pkg` holds:
  - the FSM state enum;
  - `MAG_W` and `MAG_LAT`, selected by `XCORR_PEAK_SQ_MAG_EN`;
  - an I/Q field-split helper.
- Sub-module `xcorr_mag`: the magnitude pipeline plus the valid/index/last tag shift chain (depth MAG_LAT), with `enable` gating. The top level holds the FSM, counter and compare/track registers.

## Test plan
- Impulse: arm, 128 strobes of zero except index 37 = {I=1000, Q=−500}; threshold 1000 → `peak_valid` at T+3, idx 37, mag 1500 (1250000 with macro), found=1.
- Tie and threshold miss: equal magnitude 200 at indices 10 and 90, threshold 500 → idx 10, mag 200, found=0.
- Extreme value: index 5 = {I=−2^31, Q=−2^31} → mag 2^32 (2^63 with macro); no overflow.
- Gapped input: strobes every 3rd cycle, with `enable` low for 4 cycles mid-window → same idx/mag as gap-free run; latency stretched by exactly the enable-low cycles.
- Restart: `start` again at index 60 with larger values in the old window → no `peak_valid` for the first window; second result indexes from the new arm.
- Reset mid-window at index 50 → outputs 0, `busy`=0 next cycle, no `peak_valid`; a subsequent arm works normally.
